// File: rtl/ps2_key_fifo_pkg.sv
// Shared constants for the PS/2 key event FIFO: register map, status bits, entry layout.
package ps2_key_fifo_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_CODE   = 2'd1,
    REG_FLAGS  = 2'd2,
    REG_CTRL   = 2'd3
  } reg_off_e;

  localparam int ST_EMPTY = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_OVF   = 5;
  localparam int ENTRY_W  = 10;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } key_entry_t;

endpackage

// File: rtl/ps2_key_fifo_fifo.sv
// Generic synchronous FIFO: registered pointers/count, combinational head read, sync clear.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  localparam int D = 2**AW;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(D));
  assign do_pop  = pop & ~empty;
  // A real pop frees the slot the same cycle, so a push into a full FIFO still fits.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rp_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wp_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 key event queue with a 4-register CPU window; pops on the trailing edge of a head read.
module ps2_key_fifo
  import ps2_key_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  dout,
  output logic        irq_n
);
  logic        tog_q, rd_q, irq_q;
  logic        ovf_q, ovf_d;
  logic        evt, push, pop, clr, rd_act;
  logic        f_empty, f_full;
  logic [DEPTH_LOG2:0] f_count;
  logic [4:0]  cnt5;
  key_entry_t  wr_e, hd_e;

  assign evt    = ps2_key[10] ^ tog_q;
  assign clr    = cs & ~wr_n & (addr == REG_CTRL);
  assign push   = evt & ~clr;
  assign rd_act = cs & ~rd_n & (addr == REG_CODE);
  assign pop    = rd_q & ~rd_act;
  assign wr_e   = key_entry_t'(ps2_key[ENTRY_W-1:0]);

  sync_fifo #(.W(ENTRY_W), .AW(DEPTH_LOG2)) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .wdata (wr_e),
    .rdata (hd_e),
    .count (f_count),
    .empty (f_empty),
    .full  (f_full)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (clr)                          ovf_d = 1'b0;
    else if (push && f_full && !pop)  ovf_d = 1'b1;
  end

  // Toggle copy loads the live bit in reset so the idle level is not seen as an event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= ps2_key[10];
      rd_q  <= 1'b0;
      ovf_q <= 1'b0;
      irq_q <= 1'b1;
    end else begin
      tog_q <= ps2_key[10];
      rd_q  <= rd_act;
      ovf_q <= ovf_d;
      irq_q <= f_empty;
    end
  end

  assign irq_n = irq_q;
  assign cnt5  = 5'(f_count);

  always_comb begin
    dout = 8'h00;
    case (addr)
      REG_STATUS: begin
        dout           = {3'b000, cnt5};
        dout[ST_EMPTY] = f_empty;
        dout[ST_FULL]  = f_full;
        dout[ST_OVF]   = ovf_q;
      end
      REG_CODE:  if (!f_empty) dout = hd_e.code;
      REG_FLAGS: if (!f_empty) dout = {6'b0, hd_e.pressed, hd_e.extended};
      default:   dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: vector table plus hand sequences for multi-cycle corners.
module tb_ps2_key_fifo;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        cs, rd_n, wr_n;
  logic [1:0]  addr;
  logic [7:0]  dout;
  logic        irq_n;

  int nvec = 0;
  int nerr = 0;

  ps2_key_fifo #(.DEPTH_LOG2(4)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .cs      (cs),
    .addr    (addr),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .dout    (dout),
    .irq_n   (irq_n)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         op;    // 0 idle, 1 push event, 2 one-cycle read of offset 1
    logic [7:0] code;
    logic       pr;
    logic       ex;
    logic [1:0] a;
    logic [7:0] exp;
    logic       irq;
  } vec_t;

  vec_t tbl[17];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic rd_reg(input string nm, input logic [1:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(nm, dout, exp);
  endtask

  task automatic push_ev(input logic [7:0] code, input logic pr, input logic ex);
    ps2_key = {~ps2_key[10], pr, ex, code};
    tick();
  endtask

  task automatic pop1();
    cs = 1'b1; addr = 2'd1; rd_n = 1'b0;
    tick();
    rd_n = 1'b1;
    tick();
    cs = 1'b0;
  endtask

  task automatic clear_fifo(input logic flip);
    cs = 1'b1; addr = 2'd3; wr_n = 1'b0;
    if (flip) ps2_key[10] = ~ps2_key[10];
    tick();
    wr_n = 1'b1; cs = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 8'h1C, 1'b1, 1'b0, 2'd0, 8'h01, 1'b0};
    tbl[1]  = '{0, 8'h00, 1'b0, 1'b0, 2'd1, 8'h1C, 1'b0};
    tbl[2]  = '{0, 8'h00, 1'b0, 1'b0, 2'd2, 8'h02, 1'b0};
    tbl[3]  = '{1, 8'h2A, 1'b0, 1'b1, 2'd0, 8'h02, 1'b0};
    tbl[4]  = '{1, 8'h33, 1'b1, 1'b1, 2'd0, 8'h03, 1'b0};
    tbl[5]  = '{2, 8'h00, 1'b0, 1'b0, 2'd1, 8'h2A, 1'b0};
    tbl[6]  = '{0, 8'h00, 1'b0, 1'b0, 2'd2, 8'h01, 1'b0};
    tbl[7]  = '{2, 8'h00, 1'b0, 1'b0, 2'd1, 8'h33, 1'b0};
    tbl[8]  = '{0, 8'h00, 1'b0, 1'b0, 2'd2, 8'h03, 1'b0};
    tbl[9]  = '{0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0};
    tbl[10] = '{2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h80, 1'b1};
    tbl[11] = '{2, 8'h00, 1'b0, 1'b0, 2'd0, 8'h80, 1'b1};
    tbl[12] = '{0, 8'h00, 1'b0, 1'b0, 2'd1, 8'h00, 1'b1};
    tbl[13] = '{0, 8'h00, 1'b0, 1'b0, 2'd2, 8'h00, 1'b1};
    tbl[14] = '{0, 8'h00, 1'b0, 1'b0, 2'd3, 8'h00, 1'b1};
    tbl[15] = '{1, 8'h5A, 1'b1, 1'b0, 2'd0, 8'h01, 1'b0};
    tbl[16] = '{0, 8'h00, 1'b0, 1'b0, 2'd1, 8'h5A, 1'b0};

    reset_n = 1'b0; ps2_key = '0; cs = 1'b0; addr = 2'd0; rd_n = 1'b1; wr_n = 1'b1;
    tick(); tick();
    rd_reg("rst_status", 2'd0, 8'h80);
    rd_reg("rst_code", 2'd1, 8'h00);
    rd_reg("rst_flags", 2'd2, 8'h00);
    chk("rst_irq", {7'd0, irq_n}, 8'h01);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      case (tbl[i].op)
        1: push_ev(tbl[i].code, tbl[i].pr, tbl[i].ex);
        2: pop1();
        default: tick();
      endcase
      tick();
      rd_reg($sformatf("vec%0d_dout", i), tbl[i].a, tbl[i].exp);
      chk($sformatf("vec%0d_irq", i), {7'd0, irq_n}, {7'd0, tbl[i].irq});
    end

    // irq latency: one edge after the push irq_n is still high, low after the second
    clear_fifo(1'b0);
    tick();
    push_ev(8'h1C, 1'b1, 1'b0);
    chk("irq_lat1", {7'd0, irq_n}, 8'h01);
    tick();
    chk("irq_lat2", {7'd0, irq_n}, 8'h00);

    // multi-cycle read pops exactly once, at its end
    clear_fifo(1'b0);
    push_ev(8'h11, 1'b1, 1'b0);
    push_ev(8'h22, 1'b1, 1'b0);
    push_ev(8'h33, 1'b1, 1'b0);
    cs = 1'b1; addr = 2'd1; rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("longrd_c%0d", i), dout, 8'h11);
    end
    rd_n = 1'b1;
    tick();
    cs = 1'b0;
    rd_reg("longrd_status", 2'd0, 8'h02);
    rd_reg("longrd_head", 2'd1, 8'h22);

    // overflow after 17 pushes
    clear_fifo(1'b0);
    for (int i = 0; i < 17; i++) push_ev(8'h40 + 8'(i), 1'b1, 1'b0);
    rd_reg("full_status", 2'd0, 8'h70);
    rd_reg("full_head", 2'd1, 8'h40);

    // full FIFO: push coincident with read end is accepted
    cs = 1'b1; addr = 2'd1; rd_n = 1'b0;
    tick();
    rd_n = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h99};
    tick();
    cs = 1'b0;
    rd_reg("fullpp_status", 2'd0, 8'h70);
    for (int i = 0; i < 16; i++) begin
      rd_reg($sformatf("drain%0d", i), 2'd1, (i < 15) ? 8'h41 + 8'(i) : 8'h99);
      pop1();
    end
    tick();
    rd_reg("drained_status", 2'd0, 8'hA0);
    chk("drained_irq", {7'd0, irq_n}, 8'h01);

    // clear with a coincident event
    clear_fifo(1'b0);
    push_ev(8'h01, 1'b1, 1'b0);
    push_ev(8'h02, 1'b1, 1'b0);
    tick();
    chk("pre_clr_irq", {7'd0, irq_n}, 8'h00);
    clear_fifo(1'b1);
    rd_reg("clr_status", 2'd0, 8'h80);
    chk("clr_irq_same", {7'd0, irq_n}, 8'h00);
    tick();
    chk("clr_irq_next", {7'd0, irq_n}, 8'h01);
    rd_reg("clr_status2", 2'd0, 8'h80);

    // reset mid-read, release with toggle bit high
    if (ps2_key[10]) clear_fifo(1'b1);
    push_ev(8'h0A, 1'b1, 1'b0);
    push_ev(8'h0B, 1'b1, 1'b0);
    rd_reg("prerst_status", 2'd0, 8'h02);
    cs = 1'b1; addr = 2'd1; rd_n = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    ps2_key[10] = 1'b1;
    rd_n = 1'b1; cs = 1'b0;
    rd_reg("inrst_status", 2'd0, 8'h80);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    rd_reg("postrst_status", 2'd0, 8'h80);
    rd_reg("postrst_code", 2'd1, 8'h00);
    chk("postrst_irq", {7'd0, irq_n}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
